decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parametrised instruction-decode pipeline stage between fetch and register-file/execute.
- Slices the instruction into opcode and register fields and decodes control signals: write enable, read enables, load/store, immediate and illegal-opcode flag.
- Registers the result behind a valid/ready handshake.
- Inserts a one-cycle bubble on load-use hazards and supports a synchronous pipeline flush.

Parameters:
- OP_W, 4, opcode width (instruction MSBs).
- REG_W, 4, register address width.
- INSTR_W, OP_W+4*REG_W (20), instruction width. Fields, MSB first: OP, F0, F1, F2, F3.
- IMM_W, 16, immediate output width. {F2,F3} zero-extended to IMM_W.
- LOAD_USE_STALL, 1, 1 enables hazard bubble insertion; 0 disables it.
- ZERO_REG_HW, 1, 1 means register 0 never creates a hazard.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous; kills the held output and any pending hazard
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  INSTR_W  instruction word
- out_valid  out  1  decoded instruction held
- out_ready  in  1  execute accepts the held instruction
- out_op  out  OP_W  opcode
- out_wr_en  out  1  instruction writes a register
- out_wr_addr  out  REG_W  destination register
- out_rd_en1, out_rd_en2  out  1 each  source operand used
- out_rd_addr1, out_rd_addr2  out  REG_W each  source registers
- out_imm  out  IMM_W  immediate
- out_is_load, out_is_store  out  1 each  memory-operation class
- out_illegal  out  1  opcode not in the defined set
- hazard_stall  out  1  pulses for each inserted bubble

Behaviour:
- Reset: every output register goes to 0, including out_valid and hazard_stall. in_ready is 1 the cycle after reset. Reset mid-transfer discards the held instruction.
- Decode:
  - NOP 0000: no write, no reads.
  - ADD 0001, SUB 0010, AND 0011, OR 0100: wr=F0, rd1=F1, rd2=F2.
  - ADDI 0101: wr=F0, rd1=F1, imm={F2,F3}.
  - LOAD 1011: wr=F0, rd1=F1 (base), imm={F2,F3}, is_load.
  - STORE 1100: no write, rd1=F0 (data), rd2=F1 (base), imm={F2,F3}, is_store.
  - Any other opcode: decodes as NOP with out_illegal=1.
  - Unused address fields output 0 with their enables 0.
- Handshake:
  - Latency is 1 cycle: an instruction accepted at edge N appears at out_* after edge N.
  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
  - Accept occurs when in_valid && in_ready. The output register loads and out_valid=1.
  - If out_valid && out_ready with no accept, out_valid goes to 0.
  - While out_valid && !out_ready, all out_* hold stable.
  - Full throughput, one per cycle, when no hazard is present.
- Hazard (LOAD_USE_STALL=1): hazard is asserted when all of the following hold:
  - out_valid, out_is_load, out_wr_en;
  - in_valid;
  - the incoming instruction reads out_wr_addr through an enabled rd1 or rd2;
  - the address is non-zero, or ZERO_REG_HW=0.
- Hazard response:
  - in_ready=0 for that cycle.
  - When out_ready is 1 the load leaves, out_valid goes to 0 (the bubble), and hazard_stall=1 for that cycle.
  - Next cycle there is no hazard and the instruction is accepted normally.
  - If out_ready=0 the stage simply holds; no extra bubble is inserted.
- Flush: has priority over accept and hold. The next edge sets out_valid=0 and hazard_stall=0. in_ready=0 in the flush cycle.
- Combined flush and reset: reset dominates.
- Widths: out_imm = zero-extended {F2,F3}. If IMM_W < 2*REG_W, the LSBs are kept.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams (OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LOAD, OP_STORE);
  - field-offset functions derived from OP_W and REG_W;
  - the decoded-control struct.
- One combinational sub-module, decode_ctrl: opcode plus fields in, control struct out.
- decode_stage owns the handshake, hazard logic and output register.

Test Plan:
- Reset, then ADD 0x1_3_5_7_0 with out_ready=1 -> next cycle out_valid=1, wr_addr=3, rd_addr1=5, rd_addr2=7, wr_en=1, rd_en1=rd_en2=1, illegal=0.
- STORE 0xC_2_4_0_8 -> wr_en=0, rd_addr1=2, rd_addr2=4, imm=0x0008, is_store=1.
- LOAD 0xB_6_1_0_4 followed by ADD 0x1_2_6_3_0 -> one bubble cycle with hazard_stall=1 and out_valid=0, then the ADD appears. Repeat with LOAD_USE_STALL=0 -> no bubble.
- out_ready held 0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0. Release -> the queued instruction enters the following cycle.
- Opcode 0xF -> out_illegal=1, wr_en=0, rd_en1=rd_en2=0.
- flush asserted with a held LOAD and a pending hazard -> next cycle out_valid=0, hazard_stall=0. Reset during a stall -> all outputs 0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared opcode map, instruction field offsets and decoded-control types for the decode stage.
package decode_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'hb;
    localparam logic [3:0] OP_STORE = 4'hc;

    // Opcode sits above the four register fields.
    function automatic int unsigned op_lsb(int unsigned reg_w);
        return 4 * reg_w;
    endfunction

    // idx 0..3 selects F0..F3; F0 is the most significant field.
    function automatic int unsigned fld_lsb(int unsigned reg_w, int unsigned idx);
        return (3 - idx) * reg_w;
    endfunction

    typedef enum logic [1:0] {
        FldF0,
        FldF1,
        FldF2,
        FldNone
    } field_sel_e;

    // Control flags consumed by the pipeline register and hazard logic.
    typedef struct packed {
        logic wr_en;
        logic rd_en1;
        logic rd_en2;
        logic is_load;
        logic is_store;
        logic illegal;
    } ctrl_t;

    // Field routing used only inside the decoder.
    typedef struct packed {
        field_sel_e wr_sel;
        field_sel_e rd1_sel;
        field_sel_e rd2_sel;
        logic       use_imm;
    } route_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode decoder: control flags, register addresses and immediate.
module decode_ctrl
    import decode_pkg::*;
#(
    parameter int unsigned OP_W  = 4,
    parameter int unsigned REG_W = 4,
    parameter int unsigned IMM_W = 16
) (
    input  logic [OP_W-1:0]  op,
    input  logic [REG_W-1:0] f0,
    input  logic [REG_W-1:0] f1,
    input  logic [REG_W-1:0] f2,
    input  logic [REG_W-1:0] f3,
    output ctrl_t            ctrl,
    output logic [REG_W-1:0] wr_addr,
    output logic [REG_W-1:0] rd_addr1,
    output logic [REG_W-1:0] rd_addr2,
    output logic [IMM_W-1:0] imm
);

    route_t route;
    logic [IMM_W+2*REG_W-1:0] imm_ext;

    always_comb begin
        ctrl          = '0;
        route.wr_sel  = FldNone;
        route.rd1_sel = FldNone;
        route.rd2_sel = FldNone;
        route.use_imm = 1'b0;
        unique case (op)
            OP_W'(OP_NOP): begin
            end
            OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_AND), OP_W'(OP_OR): begin
                ctrl.wr_en    = 1'b1;
                ctrl.rd_en1   = 1'b1;
                ctrl.rd_en2   = 1'b1;
                route.wr_sel  = FldF0;
                route.rd1_sel = FldF1;
                route.rd2_sel = FldF2;
            end
            OP_W'(OP_ADDI), OP_W'(OP_LOAD): begin
                ctrl.wr_en    = 1'b1;
                ctrl.rd_en1   = 1'b1;
                ctrl.is_load  = (op == OP_W'(OP_LOAD));
                route.wr_sel  = FldF0;
                route.rd1_sel = FldF1;
                route.use_imm = 1'b1;
            end
            OP_W'(OP_STORE): begin
                ctrl.rd_en1   = 1'b1;
                ctrl.rd_en2   = 1'b1;
                ctrl.is_store = 1'b1;
                route.rd1_sel = FldF0;
                route.rd2_sel = FldF1;
                route.use_imm = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

    function automatic logic [REG_W-1:0] pick(field_sel_e sel, logic [REG_W-1:0] a,
                                              logic [REG_W-1:0] b, logic [REG_W-1:0] c);
        unique case (sel)
            FldF0:   return a;
            FldF1:   return b;
            FldF2:   return c;
            default: return '0;
        endcase
    endfunction

    assign wr_addr  = pick(route.wr_sel, f0, f1, f2);
    assign rd_addr1 = pick(route.rd1_sel, f0, f1, f2);
    assign rd_addr2 = pick(route.rd2_sel, f0, f1, f2);

    // Widen first so a narrow IMM_W keeps the LSBs and a wide one zero-extends.
    assign imm_ext = {{IMM_W{1'b0}}, f2, f3};
    assign imm     = route.use_imm ? imm_ext[IMM_W-1:0] : '0;

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: field slicing, control decode, load-use bubble and flush,
// with a single registered output behind a valid/ready handshake.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned OP_W           = 4,
    parameter int unsigned REG_W          = 4,
    parameter int unsigned INSTR_W        = OP_W + 4 * REG_W,
    parameter int unsigned IMM_W          = 16,
    parameter bit          LOAD_USE_STALL = 1'b1,
    parameter bit          ZERO_REG_HW    = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    out_op,
    output logic               out_wr_en,
    output logic [REG_W-1:0]   out_wr_addr,
    output logic               out_rd_en1,
    output logic               out_rd_en2,
    output logic [REG_W-1:0]   out_rd_addr1,
    output logic [REG_W-1:0]   out_rd_addr2,
    output logic [IMM_W-1:0]   out_imm,
    output logic               out_is_load,
    output logic               out_is_store,
    output logic               out_illegal,
    output logic               hazard_stall
);

    logic [OP_W-1:0]  dec_op;
    logic [REG_W-1:0] fld0, fld1, fld2, fld3;
    ctrl_t            dec_ctrl;
    logic [REG_W-1:0] dec_wr_addr, dec_rd_addr1, dec_rd_addr2;
    logic [IMM_W-1:0] dec_imm;

    assign dec_op = in_instr[op_lsb(REG_W) +: OP_W];
    assign fld0   = in_instr[fld_lsb(REG_W, 0) +: REG_W];
    assign fld1   = in_instr[fld_lsb(REG_W, 1) +: REG_W];
    assign fld2   = in_instr[fld_lsb(REG_W, 2) +: REG_W];
    assign fld3   = in_instr[fld_lsb(REG_W, 3) +: REG_W];

    decode_ctrl #(
        .OP_W  (OP_W),
        .REG_W (REG_W),
        .IMM_W (IMM_W)
    ) u_decode_ctrl (
        .op       (dec_op),
        .f0       (fld0),
        .f1       (fld1),
        .f2       (fld2),
        .f3       (fld3),
        .ctrl     (dec_ctrl),
        .wr_addr  (dec_wr_addr),
        .rd_addr1 (dec_rd_addr1),
        .rd_addr2 (dec_rd_addr2),
        .imm      (dec_imm)
    );

    logic             valid_q, valid_d;
    logic             stall_q, stall_d;
    logic             load_en;
    logic [OP_W-1:0]  op_q;
    logic             wr_en_q, rd_en1_q, rd_en2_q;
    logic [REG_W-1:0] wr_addr_q, rd_addr1_q, rd_addr2_q;
    logic [IMM_W-1:0] imm_q;
    logic             is_load_q, is_store_q, illegal_q;

    logic src_hit;
    logic hazard;
    logic accept;

    // Incoming instruction sources the register the held load is about to write.
    assign src_hit = (dec_ctrl.rd_en1 && (dec_rd_addr1 == wr_addr_q)) ||
                     (dec_ctrl.rd_en2 && (dec_rd_addr2 == wr_addr_q));

    assign hazard = LOAD_USE_STALL && valid_q && is_load_q && wr_en_q && in_valid && src_hit &&
                    ((wr_addr_q != '0) || !ZERO_REG_HW);

    assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        stall_d = 1'b0;
        load_en = 1'b0;
        if (flush) begin
            valid_d = 1'b0;
        end else begin
            // A hazard drains the held load without refilling: that empty slot is the bubble.
            stall_d = hazard && out_ready;
            if (accept) begin
                valid_d = 1'b1;
                load_en = 1'b1;
            end else if (out_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q    <= 1'b0;
            stall_q    <= 1'b0;
            op_q       <= '0;
            wr_en_q    <= 1'b0;
            rd_en1_q   <= 1'b0;
            rd_en2_q   <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr1_q <= '0;
            rd_addr2_q <= '0;
            imm_q      <= '0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            stall_q <= stall_d;
            if (load_en) begin
                op_q       <= dec_op;
                wr_en_q    <= dec_ctrl.wr_en;
                rd_en1_q   <= dec_ctrl.rd_en1;
                rd_en2_q   <= dec_ctrl.rd_en2;
                wr_addr_q  <= dec_wr_addr;
                rd_addr1_q <= dec_rd_addr1;
                rd_addr2_q <= dec_rd_addr2;
                imm_q      <= dec_imm;
                is_load_q  <= dec_ctrl.is_load;
                is_store_q <= dec_ctrl.is_store;
                illegal_q  <= dec_ctrl.illegal;
            end
        end
    end

    assign out_valid    = valid_q;
    assign hazard_stall = stall_q;
    assign out_op       = op_q;
    assign out_wr_en    = wr_en_q;
    assign out_wr_addr  = wr_addr_q;
    assign out_rd_en1   = rd_en1_q;
    assign out_rd_en2   = rd_en2_q;
    assign out_rd_addr1 = rd_addr1_q;
    assign out_rd_addr2 = rd_addr2_q;
    assign out_imm      = imm_q;
    assign out_is_load  = is_load_q;
    assign out_is_store = is_store_q;
    assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a bubble-inserting and a non-stalling instance share stimulus and
// are compared each cycle against a transaction-level model of the stage.
module tb_decode_stage;

    logic        clock;
    logic        reset, flush, in_valid, out_ready;
    logic [19:0] in_instr;

    logic        in_ready_a, out_valid_a, wr_en_a, rd_en1_a, rd_en2_a, ld_a, st_a, ill_a, stall_a;
    logic [3:0]  op_a, wr_a, rd1_a, rd2_a;
    logic [15:0] imm_a;
    logic        in_ready_b, out_valid_b, wr_en_b, rd_en1_b, rd_en2_b, ld_b, st_b, ill_b, stall_b;
    logic [3:0]  op_b, wr_b, rd1_b, rd2_b;
    logic [15:0] imm_b;

    decode_stage #(.LOAD_USE_STALL(1'b1)) dut_a (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_instr(in_instr), .out_valid(out_valid_a), .out_ready(out_ready), .out_op(op_a),
        .out_wr_en(wr_en_a), .out_wr_addr(wr_a), .out_rd_en1(rd_en1_a), .out_rd_en2(rd_en2_a),
        .out_rd_addr1(rd1_a), .out_rd_addr2(rd2_a), .out_imm(imm_a), .out_is_load(ld_a),
        .out_is_store(st_a), .out_illegal(ill_a), .hazard_stall(stall_a)
    );

    decode_stage #(.LOAD_USE_STALL(1'b0)) dut_b (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_instr(in_instr), .out_valid(out_valid_b), .out_ready(out_ready), .out_op(op_b),
        .out_wr_en(wr_en_b), .out_wr_addr(wr_b), .out_rd_en1(rd_en1_b), .out_rd_en2(rd_en2_b),
        .out_rd_addr1(rd1_b), .out_rd_addr2(rd2_b), .out_imm(imm_b), .out_is_load(ld_b),
        .out_is_store(st_b), .out_illegal(ill_b), .hazard_stall(stall_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic [3:0]  op;
        logic        wr_en;
        logic [3:0]  wr;
        logic        r1en;
        logic [3:0]  r1;
        logic        r2en;
        logic [3:0]  r2;
        logic [15:0] imm;
        logic        ld;
        logic        st;
        logic        ill;
    } rec_t;

    int   total = 0;
    int   bad = 0;
    rec_t m_rec[2];
    logic m_valid[2];
    logic m_stall[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // What an instruction word means, straight from the opcode table.
    function automatic rec_t spec_decode(input logic [19:0] w);
        rec_t r;
        logic [3:0] op, f0, f1, f2, f3;
        {op, f0, f1, f2, f3} = w;
        r = '0;
        r.op = op;
        case (op)
            4'h0: ;
            4'h1, 4'h2, 4'h3, 4'h4: begin
                r.wr_en = 1; r.wr = f0; r.r1en = 1; r.r1 = f1; r.r2en = 1; r.r2 = f2;
            end
            4'h5: begin
                r.wr_en = 1; r.wr = f0; r.r1en = 1; r.r1 = f1; r.imm = {8'h00, f2, f3};
            end
            4'hb: begin
                r.wr_en = 1; r.wr = f0; r.r1en = 1; r.r1 = f1; r.imm = {8'h00, f2, f3}; r.ld = 1;
            end
            4'hc: begin
                r.r1en = 1; r.r1 = f0; r.r2en = 1; r.r2 = f1; r.imm = {8'h00, f2, f3}; r.st = 1;
            end
            default: r.ill = 1;
        endcase
        return r;
    endfunction

    function automatic rec_t observed(input int k);
        if (k == 0)
            return {op_a, wr_en_a, wr_a, rd_en1_a, rd1_a, rd_en2_a, rd2_a, imm_a, ld_a, st_a, ill_a};
        return {op_b, wr_en_b, wr_b, rd_en1_b, rd1_b, rd_en2_b, rd2_b, imm_b, ld_b, st_b, ill_b};
    endfunction

    // One clock: drive, check the combinational ready, advance the model, check the outputs.
    task automatic cyc(input logic rst, input logic fl, input logic iv, input logic [19:0] ins,
                       input logic ordy);
        logic n_valid[2];
        logic n_stall[2];
        rec_t n_rec[2];
        reset = rst; flush = fl; in_valid = iv; in_instr = ins; out_ready = ordy;
        #1;
        for (int k = 0; k < 2; k++) begin
            rec_t d;
            logic uses_load, hz, rdy, consumed;
            d = spec_decode(ins);
            uses_load = (d.r1en && d.r1 == m_rec[k].wr) || (d.r2en && d.r2 == m_rec[k].wr);
            hz = (k == 0) && m_valid[k] && m_rec[k].ld && m_rec[k].wr_en && iv && uses_load
                 && (m_rec[k].wr != 4'h0);
            rdy = (!m_valid[k] || ordy) && !hz && !fl;
            consumed = m_valid[k] && ordy;
            if (!rst) chk(k == 0 ? "in_ready_a" : "in_ready_b",
                          64'(k == 0 ? in_ready_a : in_ready_b), 64'(rdy));
            n_rec[k] = m_rec[k];
            n_stall[k] = 1'b0;
            n_valid[k] = m_valid[k];
            if (rst) begin
                n_valid[k] = 0; n_rec[k] = '0;
            end else if (fl) begin
                n_valid[k] = 0;
            end else if (iv && rdy) begin
                n_valid[k] = 1; n_rec[k] = d;
            end else if (consumed) begin
                n_valid[k] = 0;
                n_stall[k] = hz;
            end
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = n_valid[k];
            m_stall[k] = n_stall[k];
            m_rec[k] = n_rec[k];
            chk(k == 0 ? "out_valid_a" : "out_valid_b",
                64'(k == 0 ? out_valid_a : out_valid_b), 64'(m_valid[k]));
            chk(k == 0 ? "stall_a" : "stall_b",
                64'(k == 0 ? stall_a : stall_b), 64'(m_stall[k]));
            chk(k == 0 ? "fields_a" : "fields_b", 64'(observed(k)), 64'(m_rec[k]));
        end
    endtask

    initial begin
        logic [3:0] op;
        m_rec[0] = '0; m_rec[1] = '0;
        m_valid[0] = 0; m_valid[1] = 0;
        m_stall[0] = 0; m_stall[1] = 0;

        cyc(1, 0, 0, 20'h0, 0);
        cyc(1, 0, 0, 20'h0, 0);
        chk("reset_all_zero", 64'({observed(0), out_valid_a, stall_a}), 64'(0));

        cyc(0, 0, 1, 20'h13570, 1);
        chk("add_valid", 64'(out_valid_a), 64'(1));
        chk("add_addrs", 64'({wr_a, rd1_a, rd2_a}), 64'(12'h357));
        chk("add_en", 64'({wr_en_a, rd_en1_a, rd_en2_a, ill_a}), 64'(4'b1110));

        cyc(0, 0, 1, 20'hC2408, 1);
        chk("store_fields", 64'({wr_en_a, rd1_a, rd2_a, imm_a, st_a}), 64'({1'b0, 8'h24, 16'h0008, 1'b1}));

        // Load-use: bubble only in the stalling instance.
        cyc(0, 0, 1, 20'hB6104, 1);
        cyc(0, 0, 1, 20'h12630, 1);
        chk("bubble_a", 64'({out_valid_a, stall_a}), 64'(2'b01));
        chk("nobubble_b", 64'({out_valid_b, stall_b, op_b}), 64'({2'b10, 4'h1}));
        cyc(0, 0, 1, 20'h12630, 1);
        chk("after_bubble_a", 64'({out_valid_a, op_a, wr_a}), 64'({1'b1, 4'h1, 4'h2}));

        // Backpressure for three cycles, then release.
        cyc(0, 0, 1, 20'h4ABC0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 20'h51234, 0);
        chk("held_op", 64'(op_a), 64'(4'h4));
        cyc(0, 0, 1, 20'h51234, 1);
        chk("released_addi", 64'({op_a, imm_a}), 64'({4'h5, 16'h0034}));

        cyc(0, 0, 1, 20'hF1234, 1);
        chk("illegal", 64'({ill_a, wr_en_a, rd_en1_a, rd_en2_a}), 64'(4'b1000));

        // Flush with a held load and a pending hazard, with and without out_ready.
        cyc(0, 0, 1, 20'hB6104, 1);
        cyc(0, 1, 1, 20'h12630, 1);
        chk("flush_ordy", 64'({out_valid_a, stall_a}), 64'(0));
        cyc(0, 0, 1, 20'hB6104, 1);
        cyc(0, 1, 1, 20'h12630, 0);
        chk("flush_hold", 64'({out_valid_a, stall_a}), 64'(0));

        // Reset while a hazard is holding.
        cyc(0, 0, 1, 20'hB6104, 1);
        cyc(0, 0, 1, 20'h12630, 0);
        chk("hold_no_bubble", 64'({out_valid_a, stall_a}), 64'(2'b10));
        cyc(1, 0, 1, 20'h12630, 0);
        chk("reset_in_stall", 64'({observed(0), out_valid_a, stall_a}), 64'(0));
        cyc(0, 0, 0, 20'h0, 1);

        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 9))
                0: op = 4'h0;
                1: op = 4'h1;
                2: op = 4'h2;
                3: op = 4'h3;
                4: op = 4'h4;
                5: op = 4'h5;
                6, 7: op = 4'hb;
                8: op = 4'hc;
                default: op = 4'($urandom_range(0, 15));
            endcase
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15))},
                $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
